// File: rtl/axil_csr_pkg.sv
// Shared types and constants for the AXI4-Lite to CSR RAM bridge.
package axil_csr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_DONE = 2'd3
    } csr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/axil_csr_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axil_csr_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 18
) ();
    logic                      awvalid;
    logic                      awready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_csr_arbiter.sv
// Two-way round-robin grant between a pending write and a pending read.
module axil_csr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);
    logic last_wr_r;
    logic gnt_wr_s;
    logic gnt_rd_s;

    // On a tie, favour whichever type did not win last time.
    always_comb begin
        gnt_wr_s = 1'b0;
        gnt_rd_s = 1'b0;
        if (req_wr && req_rd) begin
            if (last_wr_r) begin
                gnt_rd_s = 1'b1;
            end else begin
                gnt_wr_s = 1'b1;
            end
        end else begin
            gnt_wr_s = req_wr;
            gnt_rd_s = req_rd;
        end
    end

    assign gnt_wr = gnt_wr_s;
    assign gnt_rd = gnt_rd_s;

    // Remember the most recent winner; reset state means the first tie goes to write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_r <= 1'b0;
        end else if (gnt_wr_s) begin
            last_wr_r <= 1'b1;
        end else if (gnt_rd_s) begin
            last_wr_r <= 1'b0;
        end else begin
            last_wr_r <= last_wr_r;
        end
    end
endmodule

// File: rtl/axil_csr_bridge.sv
// AXI4-Lite slave that maps word-addressed accesses onto a single-port CSR RAM
// with configurable read latency and SLVERR for addresses past RAM_DEPTH.
module axil_csr_bridge
    import axil_csr_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 18,
    parameter int RAM_DEPTH     = 32'd2 ** (ADDRESS_WIDTH - $clog2(DATA_WIDTH / 32'd8)),
    parameter int RAM_LATENCY   = 1,
    localparam int STRB_W  = DATA_WIDTH / 32'd8,
    localparam int BYTE_SH = $clog2(STRB_W),
    localparam int WORD_AW = ADDRESS_WIDTH - BYTE_SH
) (
    input  logic                AXI_clock,
    input  logic                AXI_reset_n,
    axil_csr_if.slave           AXIL,
    output logic                RAM_enable,
    output logic [STRB_W-1:0]   RAM_write_enable,
    output logic [WORD_AW-1:0]  RAM_address,
    output logic [DATA_WIDTH-1:0] RAM_write_data,
    input  logic [DATA_WIDTH-1:0] RAM_read_data,
    output logic [15:0]         decode_error_count
);
    localparam logic [31:0] DEPTH_U = 32'(RAM_DEPTH);
    localparam logic [2:0]  LAT_U   = 3'(RAM_LATENCY);

    csr_state_e              state_r;
    logic                    aw_lat_r, w_lat_r, ar_lat_r;
    logic [WORD_AW-1:0]      aw_word_r, ar_word_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_W-1:0]       wstrb_r;
    logic [2:0]              cnt_r;
    logic                    err_r;
    logic                    bvalid_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    ram_en_r;
    logic [STRB_W-1:0]       ram_we_r;
    logic [WORD_AW-1:0]      ram_addr_r;
    logic [DATA_WIDTH-1:0]   ram_wdata_r;
    logic [15:0]             dec_cnt_r;

    logic awready_s, wready_s, arready_s;
    logic aw_in_range_s, ar_in_range_s;
    logic req_wr_s, req_rd_s, gnt_wr_s, gnt_rd_s;
    logic unused_low_bits_s;

    // Byte-offset bits inside a word carry no meaning for this block.
    assign unused_low_bits_s = ^{AXIL.awaddr[BYTE_SH-1:0], AXIL.araddr[BYTE_SH-1:0]};

    assign awready_s = ~(aw_lat_r | bvalid_r);
    assign wready_s  = ~(w_lat_r | bvalid_r);
    assign arready_s = ~(ar_lat_r | (state_r == READ_WAIT) | rvalid_r);

    assign aw_in_range_s = (32'(aw_word_r) < DEPTH_U);
    assign ar_in_range_s = (32'(ar_word_r) < DEPTH_U);

    // New work is only started from IDLE; a finished response must drain first.
    assign req_wr_s = (state_r == IDLE) && aw_lat_r && w_lat_r && !bvalid_r;
    assign req_rd_s = (state_r == IDLE) && ar_lat_r && !rvalid_r;

    axil_csr_arbiter u_arbiter (
        .clk    (AXI_clock),
        .rst_n  (AXI_reset_n),
        .req_wr (req_wr_s),
        .req_rd (req_rd_s),
        .gnt_wr (gnt_wr_s),
        .gnt_rd (gnt_rd_s)
    );

    // Channel latches, transaction FSM, RAM port and response registers.
    always_ff @(posedge AXI_clock or negedge AXI_reset_n) begin
        if (!AXI_reset_n) begin
            state_r     <= IDLE;
            aw_lat_r    <= 1'b0;
            w_lat_r     <= 1'b0;
            ar_lat_r    <= 1'b0;
            aw_word_r   <= '0;
            ar_word_r   <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            cnt_r       <= 3'd0;
            err_r       <= 1'b0;
            bvalid_r    <= 1'b0;
            rvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            rresp_r     <= RESP_OKAY;
            rdata_r     <= '0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= '0;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
            dec_cnt_r   <= 16'd0;
        end else begin
            ram_en_r <= 1'b0;
            ram_we_r <= '0;
            if (AXIL.awvalid && awready_s) begin
                aw_lat_r  <= 1'b1;
                aw_word_r <= AXIL.awaddr[ADDRESS_WIDTH-1:BYTE_SH];
            end
            if (AXIL.wvalid && wready_s) begin
                w_lat_r <= 1'b1;
                wdata_r <= AXIL.wdata;
                wstrb_r <= AXIL.wstrb;
            end
            if (AXIL.arvalid && arready_s) begin
                ar_lat_r  <= 1'b1;
                ar_word_r <= AXIL.araddr[ADDRESS_WIDTH-1:BYTE_SH];
            end
            if (bvalid_r && AXIL.bready) begin
                bvalid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (gnt_wr_s) begin
                        state_r <= WRITE;
                        err_r   <= !aw_in_range_s;
                        if (aw_in_range_s) begin
                            ram_en_r    <= 1'b1;
                            ram_we_r    <= wstrb_r;
                            ram_addr_r  <= aw_word_r;
                            ram_wdata_r <= wdata_r;
                        end
                    end else if (gnt_rd_s) begin
                        state_r  <= READ_WAIT;
                        cnt_r    <= 3'd0;
                        ar_lat_r <= 1'b0;
                        err_r    <= !ar_in_range_s;
                        if (ar_in_range_s) begin
                            ram_en_r   <= 1'b1;
                            ram_addr_r <= ar_word_r;
                        end
                    end
                end
                WRITE: begin
                    aw_lat_r <= 1'b0;
                    w_lat_r  <= 1'b0;
                    bvalid_r <= 1'b1;
                    bresp_r  <= err_r ? RESP_SLVERR : RESP_OKAY;
                    if (err_r) begin
                        dec_cnt_r <= sat_inc16(dec_cnt_r);
                    end
                    state_r <= IDLE;
                end
                READ_WAIT: begin
                    if (cnt_r == LAT_U) begin
                        rvalid_r <= 1'b1;
                        rresp_r  <= err_r ? RESP_SLVERR : RESP_OKAY;
                        rdata_r  <= err_r ? '0 : RAM_read_data;
                        if (err_r) begin
                            dec_cnt_r <= sat_inc16(dec_cnt_r);
                        end
                        state_r <= READ_DONE;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                READ_DONE: begin
                    if (AXIL.rready) begin
                        rvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign AXIL.awready = awready_s;
    assign AXIL.wready  = wready_s;
    assign AXIL.arready = arready_s;
    assign AXIL.bvalid  = bvalid_r;
    assign AXIL.bresp   = bresp_r;
    assign AXIL.rvalid  = rvalid_r;
    assign AXIL.rresp   = rresp_r;
    assign AXIL.rdata   = rdata_r;

    assign RAM_enable         = ram_en_r;
    assign RAM_write_enable   = ram_we_r;
    assign RAM_address        = ram_addr_r;
    assign RAM_write_data     = ram_wdata_r;
    assign decode_error_count = dec_cnt_r;
endmodule
